// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter and the CPU core.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned MEM_DATA_W = 16;
    localparam int unsigned STREAK_W   = 4;

    // Which requester is driving the memory port in the current cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive D grants taken while an instruction fetch waits.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STREAK_W-1:0] LIMIT_V = STREAK_W'(LIMIT);

    logic [STREAK_W-1:0] count;

    // Clear dominates so an I grant always restarts the streak.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + STREAK_W'(1);
        end
    end

    assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-port memory,
// registering the memory drive and capturing read data one cycle later.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = MEM_ADDR_W,
    parameter int unsigned DATA_W       = MEM_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    owner_t state;
    owner_t state_next;
    logic   at_limit;
    logic   streak_inc;
    logic   streak_clr;
    logic   cap_i;
    logic   cap_d;
    logic   done_d;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock    (clock),
        .reset    (reset),
        .inc      (streak_inc),
        .clr      (streak_clr),
        .at_limit (at_limit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants depend only on the live requests; D wins ties until the streak limit.
    always_comb begin
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        state_next = IDLE;
        if (reset) begin
            i_gnt = i_req && (!d_req || at_limit);
            d_gnt = d_req && !i_gnt;
        end
        if (i_gnt) begin
            state_next = IFETCH;
        end else if (d_gnt) begin
            state_next = DACCESS;
        end
        streak_inc = d_gnt && i_req;
        streak_clr = i_gnt || !i_req;
    end

    // The latched write enable tells a store apart from a load during DACCESS.
    always_comb begin
        cap_i  = 1'b0;
        cap_d  = 1'b0;
        done_d = 1'b0;
        case (state)
            IFETCH: begin
                cap_i = 1'b1;
            end
            DACCESS: begin
                done_d = 1'b1;
                cap_d  = !mem_we;
            end
            default: begin
                cap_i = 1'b0;
            end
        endcase
    end

    // Memory drive for the cycle after the grant; address and data hold while idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_address <= '0;
            mem_we      <= 1'b0;
            mem_data_in <= '0;
        end else begin
            mem_we <= d_gnt && d_we;
            if (i_gnt) begin
                mem_address <= i_addr;
            end else if (d_gnt) begin
                mem_address <= d_addr;
                mem_data_in <= d_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_valid <= cap_i;
            d_valid <= done_d;
            if (cap_i) begin
                i_rdata <= mem_data_out;
            end
            if (cap_d) begin
                d_rdata <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level
// model of grants, completion timing and memory contents.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [7:0]  i_addr = '0;
    logic        i_gnt;
    logic        i_valid;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_valid;
    logic [15:0] d_rdata;
    logic [7:0]  mem_address;
    logic        mem_we;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    logic [15:0] tb_mem  [256];
    logic [15:0] ref_mem [256];

    mem_arbiter #(
        .ADDR_W       (8),
        .DATA_W       (16),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_valid      (i_valid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_valid      (d_valid),
        .d_rdata      (d_rdata),
        .mem_address  (mem_address),
        .mem_we       (mem_we),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clock = ~clock;

    // Single-port memory: combinational read, posedge write.
    always @(posedge clock) begin
        if (mem_we) tb_mem[mem_address] <= mem_data_in;
    end
    assign mem_data_out = tb_mem[mem_address];

    typedef struct {
        int          due;
        bit          is_d;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] data;
    } pend_t;

    pend_t       pq[$];
    int          cyc = 0;
    int          streak = 0;
    logic [15:0] last_i = '0;
    logic [15:0] last_d = '0;
    int          errors = 0;
    int          checks = 0;

    logic        gi, gd, obs_d;
    logic        ip, dp, rwe;
    logic [7:0]  ra_i, ra_d;
    logic [15:0] rwd, old20;
    logic [11:0] seq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One bus cycle: drive requests, check completions and grants, advance the model.
    task automatic step(input logic ir, input logic [7:0] ia, input logic dr, input logic dwe,
                        input logic [7:0] da, input logic [15:0] dwd);
        logic iv, dv;
        pend_t p;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        @(negedge clock);
        iv = 1'b0;
        dv = 1'b0;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            if (p.due == cyc) begin
                if (!p.is_d) begin
                    iv = 1'b1;
                    last_i = ref_mem[p.addr];
                end else begin
                    dv = 1'b1;
                    if (p.we) ref_mem[p.addr] = p.data;
                    else last_d = ref_mem[p.addr];
                end
            end
        end
        chk("i_valid", 32'(i_valid), 32'(iv));
        chk("d_valid", 32'(d_valid), 32'(dv));
        chk("i_rdata", 32'(i_rdata), 32'(last_i));
        chk("d_rdata", 32'(d_rdata), 32'(last_d));
        gi = ir && (!dr || streak == int'(LIMIT));
        gd = dr && !gi;
        chk("i_gnt", 32'(i_gnt), 32'(gi));
        chk("d_gnt", 32'(d_gnt), 32'(gd));
        chk("gnt_excl", 32'(i_gnt & d_gnt), 32'(0));
        obs_d = d_gnt;
        if (gi) pq.push_back('{cyc + 2, 1'b0, 1'b0, ia, 16'h0});
        if (gd) pq.push_back('{cyc + 2, 1'b1, dwe, da, dwd});
        if (gi || !ir) streak = 0;
        else if (gd) streak = (streak < int'(LIMIT)) ? streak + 1 : int'(LIMIT);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_i_gnt"}, 32'(i_gnt), 32'(0));
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'(0));
        chk({tag, "_i_valid"}, 32'(i_valid), 32'(0));
        chk({tag, "_d_valid"}, 32'(d_valid), 32'(0));
        chk({tag, "_i_rdata"}, 32'(i_rdata), 32'(0));
        chk({tag, "_d_rdata"}, 32'(d_rdata), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mem_address), 32'(0));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        chk({tag, "_mem_din"}, 32'(mem_data_in), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            tb_mem[a]  = 16'($urandom);
            ref_mem[a] = tb_mem[a];
        end
        tb_mem[2]     = 16'hA1FF; ref_mem[2]     = 16'hA1FF;
        tb_mem[8'h30] = 16'h0000; ref_mem[8'h30] = 16'h0000;

        // Reset state with requests already pending.
        i_req = 1'b1; d_req = 1'b1;
        #3;
        chk_all_zero("rst");
        i_req = 1'b0; d_req = 1'b0;
        #9 reset = 1'b1;
        @(posedge clock);
        #1;

        // Single fetch: grant now, data two cycles later.
        step(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 16'h0);
        idle(3);

        // Store then immediate load of the same address.
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 16'h1234);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 16'h0);
        idle(3);
        chk("raw_mem", 32'(tb_mem[8'h10]), 32'h1234);
        chk("raw_rdata", 32'(d_rdata), 32'h1234);

        // Both requesting continuously: streak limit yields to I every fifth grant.
        seq = '0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 8'(k), 1'b1, 1'b0, 8'(8'h80 + k), 16'h0);
            seq[k] = obs_d;
        end
        chk("starve_seq", 32'(seq), 32'(12'b1101_1110_1111));
        idle(3);

        // Alternating single requests, one grant per cycle.
        step(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 16'h0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 16'h0);
        step(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 16'h0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 16'h5A5A);
        step(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 16'h0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 16'h0);
        idle(3);

        // D request loses to a starved I and is withdrawn: nothing must happen.
        for (int k = 0; k < 4; k++) step(1'b1, 8'h06, 1'b1, 1'b0, 8'(8'h90 + k), 16'h0);
        step(1'b1, 8'h06, 1'b1, 1'b1, 8'h30, 16'hBEEF);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0);
        idle(3);
        chk("drop_mem", 32'(tb_mem[8'h30]), 32'h0000);

        // Reset while a store is latched but not yet committed.
        old20 = tb_mem[8'h20];
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, ~old20);
        i_req = 1'b1; d_req = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clock);
        #1;
        chk("rst_hold_i_gnt", 32'(i_gnt), 32'(0));
        chk("rst_hold_d_gnt", 32'(d_gnt), 32'(0));
        chk("rst_no_commit", 32'(tb_mem[8'h20]), 32'(old20));
        pq.delete();
        streak = 0;
        last_i = '0;
        last_d = '0;
        #2 reset = 1'b1;
        step(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 16'h0);
        idle(3);

        // Randomized traffic over a small address window to exercise RAW and fetch-after-store.
        ip = 1'b0; dp = 1'b0; rwe = 1'b0;
        ra_i = '0; ra_d = '0; rwd = '0;
        for (int n = 0; n < 500; n++) begin
            if (!ip && $urandom_range(0, 3) != 0) begin
                ip = 1'b1;
                ra_i = 8'(8'h40 + $urandom_range(0, 7));
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1;
                rwe = 1'($urandom_range(0, 1));
                ra_d = 8'(8'h40 + $urandom_range(0, 7));
                rwd = 16'($urandom);
            end
            step(ip, ra_i, dp, rwe, ra_d, rwd);
            if (gi) ip = 1'b0;
            if (gd) dp = 1'b0;
            else if (dp && $urandom_range(0, 7) == 0) dp = 1'b0;
        end
        idle(4);

        for (int a = 0; a < 256; a++) chk("mem_final", 32'(tb_mem[a]), 32'(ref_mem[a]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer for the CPU's single-port 256x16 unified instruction/data memory (combinational read, posedge write). It sits between the CPU core and the memory. It shares the one memory port between instruction fetch (I port) and load/store (D port). Memory drive and read-data capture are registered, so back-to-back accesses are possible every cycle. A streak limit stops instruction fetch from starving.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory word width
- STARVE_LIMIT, 4, maximum consecutive D grants while I is pending; 1..15

Ports:
- clock  in  1  system clock, posedge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  instruction fetch request; held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  combinational grant for the current cycle
- i_valid  out  1  one-cycle pulse: i_rdata holds the fetched word
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  combinational grant for the current cycle
- d_valid  out  1  one-cycle completion pulse, for loads and stores
- d_rdata  out  DATA_W  load data; unchanged by stores
- mem_address  out  ADDR_W  registered memory address
- mem_we  out  1  registered memory write enable
- mem_data_in  out  DATA_W  registered memory write data
- mem_data_out  in  DATA_W  memory combinational read data

## Operation
- Owner state machine, registered: IDLE, IFETCH, DACCESS. The state names the access driving memory in the current cycle.
- Arbitration runs every cycle on the current i_req/d_req:
  - Neither requests: next state is IDLE; no grant.
  - Only one requests: grant it.
  - Both request: grant D unless streak == STARVE_LIMIT, in which case grant I.
- Streak counter, 4 bits:
  - Increments when D is granted while i_req = 1.
  - Clears when I is granted or when i_req = 0.
  - Saturates at STARVE_LIMIT.
- On grant, the granted address, we and wdata are registered into mem_address, mem_we and mem_data_in. The next state becomes IFETCH or DACCESS.
- mem_we = 1 only in DACCESS with a latched store; in all other states it is 0.
- During IFETCH, or DACCESS with a latched load, mem_data_out is captured at the end of the cycle into i_rdata or d_rdata respectively.
- In IDLE, mem_address and mem_data_in hold their last values and mem_we = 0.
- A requester may drop or change req/addr in the cycle after its grant. A requester that drops req without a grant causes nothing to happen.
- Read-after-write at the same address on consecutive D grants returns the new data, because the write commits before the read cycle.

## Timing
- Request sampled and granted in cycle N.
- Memory is driven in cycle N+1. A store commits at the posedge ending N+1.
- i_valid/d_valid pulse in cycle N+2, with rdata stable from then until the next read of that port.
- Throughput: one access per cycle. With both requesters continuously asserted and STARVE_LIMIT = 4, the grant sequence is D,D,D,D,I,D,D,D,D,I,…
- Reset asserted at any time, including with a store latched but not yet committed:
  - All outputs go to 0 immediately: gnt, valid, rdata, mem_address, mem_we, mem_data_in.
  - State returns to IDLE and the streak counter to 0.
  - The in-flight store is dropped and memory is not written.
  - Requests are ignored until the first posedge after reset deasserts.
- Grants are combinational from req, state-independent, and never asserted on both ports in one cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - the owner_t enum (IDLE, IFETCH, DACCESS)
  - default ADDR_W/DATA_W constants, shared with the CPU core
- One sub-module, arb_starve_counter: a saturating streak counter with inc/clr inputs and an at_limit output. The arbiter FSM, address/data registers and read capture stay in mem_arbiter.

## Test plan
- After reset, i_req only, i_addr = 0x02, memory[2] = 0xA1FF → i_gnt in cycle 0, i_valid with i_rdata = 0xA1FF in cycle 2; d_valid stays 0.
- d_req store 0x1234 to 0x10, then load of 0x10 in the next cycle → memory[0x10] = 0x1234, and the d_valid on the load returns d_rdata = 0x1234 two cycles after the load grant.
- i_req and d_req both held continuously for 12 cycles with STARVE_LIMIT = 4 → grants D,D,D,D,I,D,D,D,D,I,D,D; never both granted.
- Alternating single requests I,D,I,D every cycle → one grant per cycle; each valid arrives exactly 2 cycles after its grant; rdata is routed to the correct port.
- Store to 0x20 granted, then reset asserted mid-cycle N+1 before the posedge → memory[0x20] unchanged, all outputs 0 immediately, first grant occurs on the first posedge after release.
- d_req dropped before any grant while I is busy → no memory write and no d_valid.
